sram_req_ctrl: RTL and testbench

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_req_ctrl_pkg.sv | 57 +++++
 rtl/sram_req_ctrl.sv | 110 +++++++++++
 tb/tb_sram_req_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared types for the SRAM request controller: bus widths, FSM states,
// the register bundle with its reset value, and the request legality check.
package sram_req_ctrl_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Every piece of controller state lives in this one bundle.
  typedef struct packed {
    state_t                             state;
    logic [1:0]                         wait_cnt;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]    addr;
    logic [7:0]                         size;
    logic                               write;
    logic                               last;
    logic [CFG_SYSBUS_DATA_BITS-1:0]    wdata;
    logic [CFG_SYSBUS_DATA_BYTES-1:0]   wstrb;
    logic [CFG_SYSBUS_DATA_BITS-1:0]    resp_rdata;
    logic                               resp_err;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    state:      ST_IDLE,
    wait_cnt:   2'd0,
    addr:       '0,
    size:       8'd0,
    write:      1'b0,
    last:       1'b0,
    wdata:      '0,
    wstrb:      '0,
    resp_rdata: '0,
    resp_err:   1'b0
  };

  // A request is bad when its size is not 1/2/4/8 or its address is not
  // naturally aligned to that size; only the low three address bits matter.
  function automatic logic req_is_bad(input logic [7:0] size, input logic [2:0] addr_lo);
    logic bad;
    case (size)
      8'd1:    bad = 1'b0;
      8'd2:    bad = addr_lo[0];
      8'd4:    bad = |addr_lo[1:0];
      8'd8:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sram_req_ctrl.sv
// Single-request SRAM controller: accepts one bus request at a time, screens
// it for size/alignment errors, runs one SRAM cycle, waits out the read
// latency and returns a one-cycle response pulse.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int abits      = 16,
  parameter int rd_latency = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_req_valid,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]   i_req_addr,
  input  logic [7:0]                        i_req_size,
  input  logic                              i_req_write,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]   i_req_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0]  i_req_wstrb,
  input  logic                              i_req_last,
  output logic                              o_req_ready,
  output logic                              o_resp_valid,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]   o_resp_rdata,
  output logic                              o_resp_err,
  output logic                              o_mem_cs,
  output logic                              o_mem_we,
  output logic [abits-4:0]                  o_mem_addr,
  output logic [7:0]                        o_mem_wstrb,
  output logic [63:0]                       o_mem_wdata,
  input  logic [63:0]                       i_mem_rdata
);

  // The Wait state counts down from latency-1 so the last Wait cycle lines
  // up with the cycle the SRAM presents its data.
  localparam logic [1:0] WAIT_INIT = 2'(rd_latency - 1);

  regs_t r;
  regs_t v;

  // Next-state and datapath updates for the four-state request sequence.
  always_comb begin
    v = r;
    case (r.state)
      ST_IDLE: begin
        if (i_req_valid) begin
          v.addr              = '0;
          v.addr[abits-1:0]   = i_req_addr[abits-1:0];
          v.size              = i_req_size;
          v.write             = i_req_write;
          v.last              = i_req_last;
          v.wdata             = i_req_wdata;
          v.wstrb             = i_req_wstrb;
          if (req_is_bad(i_req_size, i_req_addr[2:0])) begin
            v.resp_err   = 1'b1;
            v.resp_rdata = '0;
            v.state      = ST_RESP;
          end else begin
            v.resp_err = 1'b0;
            v.state    = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (r.write) begin
          v.state = ST_RESP;
        end else begin
          v.state    = ST_WAIT;
          v.wait_cnt = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (r.wait_cnt == 2'd0) begin
          v.resp_rdata = i_mem_rdata;
          v.state      = ST_RESP;
        end else begin
          v.wait_cnt = r.wait_cnt - 2'd1;
        end
      end
      ST_RESP: begin
        v.state = ST_IDLE;
      end
      default: begin
        v = REGS_RESET;
      end
    endcase
  end

  // Register bundle update; reset abandons any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r <= REGS_RESET;
    end else begin
      r <= v;
    end
  end

  assign o_req_ready  = (r.state == ST_IDLE);
  assign o_resp_valid = (r.state == ST_RESP);
  assign o_resp_rdata = r.resp_rdata;
  assign o_resp_err   = r.resp_err;
  assign o_mem_cs     = (r.state == ST_MEM);
  assign o_mem_we     = (r.state == ST_MEM) & r.write;
  assign o_mem_addr   = r.addr[abits-1:3];
  assign o_mem_wstrb  = r.wstrb;
  assign o_mem_wdata  = r.wdata;

  // Address bits outside the window, the sub-word offset, the stored size and
  // the burst-last flag are kept for completeness but drive nothing.
  logic unused_bits;
  assign unused_bits = ^{i_req_addr, r.addr, r.size, r.last};

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: two controllers (read latency 1 and 4) share one
// request stream, each talking to its own behavioural SRAM, and are compared
// every cycle against a transaction-level model of the expected behaviour.

// Behavioural SRAM with byte-enable writes and a configurable read pipeline.
// Outside the valid read slot it presents a marker pattern so that capturing
// on the wrong cycle shows up as bad data.
module sram_model_beh #(
  parameter int abits   = 16,
  parameter int latency = 1
) (
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic [abits-4:0]  addr,
  input  logic [7:0]        wstrb,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata
);
  logic [63:0] mem  [0:(2**(abits-3))-1];
  logic [63:0] pipe [0:latency-1];

  initial begin
    for (int i = 0; i < 2**(abits-3); i++) mem[i] = 64'h0;
    for (int k = 0; k < latency; k++) pipe[k] = 64'h0;
  end

  always @(posedge clk) begin
    if (cs && we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    pipe[0] <= (cs && !we) ? mem[addr] : 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 1; k < latency; k++) pipe[k] <= pipe[k-1];
  end

  assign rdata = pipe[latency-1];
endmodule

module tb_sram_req_ctrl;
  localparam int ABITS = 16;
  localparam int LAT [2] = '{1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [7:0]  req_size;
  logic        req_write;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        req_last;

  logic        ready      [2];
  logic        resp_valid [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        mem_cs     [2];
  logic        mem_we     [2];
  logic [12:0] mem_addr   [2];
  logic [7:0]  mem_wstrb  [2];
  logic [63:0] mem_wdata  [2];
  logic [63:0] mem_rdata  [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  // Transaction-level expectations, one slot per controller.
  int          acc_t   [2];
  int          busy_hi [2];
  int          resp_cyc[2];
  int          cs_cyc  [2];
  int          rd_switch[2];
  logic [63:0] rd_old  [2];
  logic [63:0] rd_new  [2];
  logic        exp_err [2];
  logic        exp_we;
  logic [12:0] exp_maddr;
  logic [7:0]  exp_wstrb;
  logic [63:0] exp_wdata;
  logic [63:0] mem_m [int];

  // Observations recorded by the compare process for directed checks.
  int          last_resp_cyc [2];
  int          last_cs_cyc   [2];
  int          cs_count      [2];
  logic        cap_err       [2];
  logic [63:0] cap_rdata     [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_req_ctrl #(.abits(ABITS), .rd_latency(LAT[g])) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .i_req_addr   (req_addr),
      .i_req_size   (req_size),
      .i_req_write  (req_write),
      .i_req_wdata  (req_wdata),
      .i_req_wstrb  (req_wstrb),
      .i_req_last   (req_last),
      .o_req_ready  (ready[g]),
      .o_resp_valid (resp_valid[g]),
      .o_resp_rdata (resp_rdata[g]),
      .o_resp_err   (resp_err[g]),
      .o_mem_cs     (mem_cs[g]),
      .o_mem_we     (mem_we[g]),
      .o_mem_addr   (mem_addr[g]),
      .o_mem_wstrb  (mem_wstrb[g]),
      .o_mem_wdata  (mem_wdata[g]),
      .i_mem_rdata  (mem_rdata[g])
    );

    sram_model_beh #(.abits(ABITS), .latency(LAT[g])) sram (
      .clk   (clk),
      .cs    (mem_cs[g]),
      .we    (mem_we[g]),
      .addr  (mem_addr[g]),
      .wstrb (mem_wstrb[g]),
      .wdata (mem_wdata[g]),
      .rdata (mem_rdata[g])
    );
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_at(input int i, input int c);
    return (c >= rd_switch[i]) ? rd_new[i] : rd_old[i];
  endfunction

  // Expected outcome of a request accepted at cycle t, from the timing rules.
  task automatic model_accept(input int t, input logic wr, input logic [31:0] addr,
                              input logic [7:0] size, input logic [63:0] wd, input logic [7:0] ws);
    logic bad;
    int idx;
    logic [63:0] word;
    bad = !(size == 8'd1 || size == 8'd2 || size == 8'd4 || size == 8'd8);
    if (!bad) bad = (addr % size) != 0;
    idx  = int'(addr & ((32'd1 << ABITS) - 1)) / 8;
    word = mem_m.exists(idx) ? mem_m[idx] : 64'h0;
    if (!bad && wr) begin
      for (int b = 0; b < 8; b++) if (ws[b]) word[8*b +: 8] = wd[8*b +: 8];
      mem_m[idx] = word;
    end
    for (int i = 0; i < 2; i++) begin
      rd_old[i] = rd_at(i, t);
      acc_t[i]  = t;
      if (bad) begin
        cs_cyc[i]   = -10;
        resp_cyc[i] = t + 1;
        rd_new[i]   = 64'h0;
      end else if (wr) begin
        cs_cyc[i]   = t + 1;
        resp_cyc[i] = t + 2;
        rd_new[i]   = rd_old[i];
      end else begin
        cs_cyc[i]   = t + 1;
        resp_cyc[i] = t + 2 + LAT[i];
        rd_new[i]   = word;
      end
      busy_hi[i]   = resp_cyc[i];
      rd_switch[i] = resp_cyc[i];
      exp_err[i]   = bad;
    end
    exp_we    = wr;
    exp_maddr = addr[ABITS-1:3];
    exp_wstrb = ws;
    exp_wdata = wd;
  endtask

  // Reset raised during cycle c: from c+1 on, idle with cleared read data.
  task automatic model_reset(input int c);
    for (int i = 0; i < 2; i++) begin
      rd_old[i]    = rd_at(i, c);
      rd_new[i]    = 64'h0;
      rd_switch[i] = c + 1;
      busy_hi[i]   = c;
      resp_cyc[i]  = -10;
      cs_cyc[i]    = -10;
    end
  endtask

  // Per-cycle comparison of both controllers against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check_output($sformatf("ready%0d", i), 64'(ready[i]),
                     64'(!(cyc >= acc_t[i] + 1 && cyc <= busy_hi[i])));
        check_output($sformatf("cs%0d", i), 64'(mem_cs[i]), 64'(cyc == cs_cyc[i]));
        check_output($sformatf("resp_valid%0d", i), 64'(resp_valid[i]), 64'(cyc == resp_cyc[i]));
        check_output($sformatf("rdata%0d", i), resp_rdata[i], rd_at(i, cyc));
        if (cyc == cs_cyc[i]) begin
          check_output($sformatf("we%0d", i), 64'(mem_we[i]), 64'(exp_we));
          check_output($sformatf("maddr%0d", i), 64'(mem_addr[i]), 64'(exp_maddr));
          check_output($sformatf("mwstrb%0d", i), 64'(mem_wstrb[i]), 64'(exp_wstrb));
          check_output($sformatf("mwdata%0d", i), mem_wdata[i], exp_wdata);
        end
        if (cyc == resp_cyc[i]) begin
          check_output($sformatf("err%0d", i), 64'(resp_err[i]), 64'(exp_err[i]));
        end
        if (resp_valid[i] === 1'b1) begin
          last_resp_cyc[i] = cyc;
          cap_err[i]       = resp_err[i];
          cap_rdata[i]     = resp_rdata[i];
        end
        if (mem_cs[i] === 1'b1) begin
          last_cs_cyc[i] = cyc;
          cs_count[i]++;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request while both controllers are idle and wait until both respond.
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [7:0] size,
                                input logic [63:0] wd, input logic [7:0] ws, output int t);
    int done;
    t         = cyc;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wd;
    req_wstrb = ws;
    req_last  = 1'($urandom);
    model_accept(t, wr, addr, size, wd, ws);
    wait_cycles(1);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    done = (resp_cyc[0] > resp_cyc[1]) ? resp_cyc[0] : resp_cyc[1];
    while (cyc <= done) wait_cycles(1);
  endtask

  // Start a read and pull reset while both controllers sit in Wait.
  task automatic reset_abort();
    int t;
    t         = cyc;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    req_size  = 8'd8;
    model_accept(t, 1'b0, 32'h40, 8'd8, req_wdata, req_wstrb);
    wait_cycles(1);
    req_valid = 1'b0;
    wait_cycles(1);
    rst = 1'b1;
    model_reset(t + 2);
    wait_cycles(1);
    rst = 1'b0;
    check_output("rst_ready0", 64'(ready[0]), 64'd1);
    check_output("rst_ready1", 64'(ready[1]), 64'd1);
    wait_cycles(10);
    check_output("rst_noresp0", 64'(last_resp_cyc[0] > t + 2), 64'd0);
    check_output("rst_noresp1", 64'(last_resp_cyc[1] > t + 2), 64'd0);
  endtask

  initial begin
    int t;
    int cs_before;
    logic [7:0] sizes [10] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd8, 8'd8, 8'd3, 8'd0, 8'd16, 8'd6};

    for (int i = 0; i < 2; i++) begin
      acc_t[i] = -10; busy_hi[i] = -10; resp_cyc[i] = -10; cs_cyc[i] = -10;
      rd_switch[i] = 0; rd_old[i] = 64'h0; rd_new[i] = 64'h0; exp_err[i] = 1'b0;
      last_resp_cyc[i] = -10; last_cs_cyc[i] = -10; cs_count[i] = 0;
      cap_err[i] = 1'b0; cap_rdata[i] = 64'h0;
    end
    exp_we = 1'b0; exp_maddr = '0; exp_wstrb = '0; exp_wdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_write = 1'b0;
    req_wdata = '0; req_wstrb = '0; req_last = 1'b0;

    wait_cycles(1);
    chk_en = 1'b1;
    wait_cycles(2);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("reset_err%0d", i), 64'(resp_err[i]), 64'd0);
      check_output($sformatf("reset_we%0d", i), 64'(mem_we[i]), 64'd0);
      check_output($sformatf("reset_rdata%0d", i), resp_rdata[i], 64'h0);
    end
    rst = 1'b0;
    wait_cycles(1);

    $display("[TB] directed sequence");
    apply_stimulus(1'b1, 32'h40, 8'd8, 64'h1122334455667788, 8'hFF, t);
    check_output("wr_lat", 64'(last_resp_cyc[0]), 64'(t + 2));
    check_output("wr_err", 64'(cap_err[0]), 64'd0);

    apply_stimulus(1'b0, 32'h40, 8'd8, 64'h0, 8'h00, t);
    check_output("rd_lat1", 64'(last_resp_cyc[0]), 64'(t + 3));
    check_output("rd_lat4", 64'(last_resp_cyc[1]), 64'(t + 6));
    check_output("rd_cs4", 64'(last_cs_cyc[1]), 64'(t + 1));
    check_output("rd_data1", cap_rdata[0], 64'h1122334455667788);
    check_output("rd_data4", cap_rdata[1], 64'h1122334455667788);
    check_output("rd_err1", 64'(cap_err[0]), 64'd0);

    apply_stimulus(1'b1, 32'h40, 8'd8, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, t);
    apply_stimulus(1'b0, 32'h40, 8'd8, 64'h0, 8'h00, t);
    check_output("merge_data1", cap_rdata[0], 64'h11223344_BBBBBBBB);
    check_output("merge_data4", cap_rdata[1], 64'h11223344_BBBBBBBB);

    cs_before = cs_count[0];
    apply_stimulus(1'b0, 32'h42, 8'd4, 64'h0, 8'h00, t);
    check_output("mis_lat", 64'(last_resp_cyc[0]), 64'(t + 1));
    check_output("mis_err", 64'(cap_err[0]), 64'd1);
    check_output("mis_rdata", cap_rdata[0], 64'h0);
    check_output("mis_nocs", 64'(cs_count[0]), 64'(cs_before));

    apply_stimulus(1'b1, 32'h40, 8'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, t);
    check_output("zstrb_err", 64'(cap_err[0]), 64'd0);
    apply_stimulus(1'b0, 32'h40, 8'd8, 64'h0, 8'h00, t);
    check_output("zstrb_data", cap_rdata[0], 64'h11223344_BBBBBBBB);

    apply_stimulus(1'b1, 32'hABCD_FFF8, 8'd8, 64'h0123_4567_89AB_CDEF, 8'hFF, t);
    apply_stimulus(1'b0, 32'h0000_FFF8, 8'd8, 64'h0, 8'h00, t);
    check_output("top_data", cap_rdata[1], 64'h0123_4567_89AB_CDEF);
    check_output("top_err", 64'(cap_err[1]), 64'd0);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 80; n++) begin
      logic [7:0]  sz;
      logic [31:0] a;
      int          word;
      int          off;
      sz   = sizes[$urandom_range(0, 9)];
      word = ($urandom_range(0, 8) == 8) ? 32'h1FFF : $urandom_range(0, 7);
      off  = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && (sz == 8'd1 || sz == 8'd2 || sz == 8'd4 || sz == 8'd8))
        off = off & ~(int'(sz) - 1);
      a = {16'($urandom), 16'(word * 8 + off)};
      apply_stimulus(1'($urandom), a, sz, {$urandom, $urandom},
                     ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), t);
      wait_cycles($urandom_range(0, 2));
    end

    $display("[TB] reset during read wait");
    reset_abort();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
